vec_accel_slave: RTL and testbench

//  Memory-mapped vector accelerator on the UDM host bus, window 0x2000_0000.

---
 rtl/vec_accel_pkg.sv | 31 +++
 rtl/vec_accel_dp.sv | 53 +++++
 rtl/vec_accel_slave.sv | 144 ++++++++++++++
 tb/tb_vec_accel_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_accel_pkg.sv
// rtl/vec_accel_pkg.sv - shared constants, state type and byte-merge helper for the vector accelerator
package vec_accel_pkg;

  localparam int NUM_ELEMS_DEF = 8;

  // Default word map; the top re-derives these from its NUM_ELEMS parameter
  localparam int IDX_A0 = 0;
  localparam int IDX_B0 = NUM_ELEMS_DEF;
  localparam int IDX_R0 = 2 * NUM_ELEMS_DEF;
  localparam int IDX_R1 = IDX_R0 + 1;
  localparam int IDX_R2 = IDX_R0 + 2;
  localparam int IDX_R3 = IDX_R0 + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vec_accel_dp.sv
// rtl/vec_accel_dp.sv - dot-product / max-sum / min-sum datapath, one element per step strobe
module vec_accel_dp
  import vec_accel_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init,
  input  logic        step,
  input  logic        commit,
  input  logic [31:0] a_elem,
  input  logic [31:0] b_elem,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] r2
);

  logic [31:0] acc;
  logic [31:0] mx;
  logic [31:0] mn;
  logic [31:0] prod;
  logic [31:0] sum;

  assign prod = a_elem * b_elem;
  assign sum  = a_elem + b_elem;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc <= '0;
      mx  <= '0;
      mn  <= '0;
      r0  <= '0;
      r1  <= '0;
      r2  <= '0;
    end else begin
      // commit samples the finished accumulators even when init restarts them
      if (commit) begin
        r0 <= acc;
        r1 <= mx;
        r2 <= mn;
      end
      if (init) begin
        acc <= '0;
        mx  <= '0;
        mn  <= 32'hFFFF_FFFF;
      end else if (step) begin
        acc <= acc + prod;
        mx  <= (sum > mx) ? sum : mx;
        mn  <= (sum < mn) ? sum : mn;
      end
    end
  end

endmodule

// File: rtl/vec_accel_slave.sv
// rtl/vec_accel_slave.sv - host-bus slave holding operand vectors A/B and sequencing the datapath
module vec_accel_slave
  import vec_accel_pkg::*;
#(
  parameter int NUM_ELEMS = NUM_ELEMS_DEF,
  parameter int ADDR_LSBS = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [3:0]  host_be,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        host_resp,
  output logic [31:0] host_rdata
);

  localparam int IW = ADDR_LSBS - 2;
  localparam int EW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IW-1:0] B0_IDX = IW'(NUM_ELEMS);
  localparam logic [IW-1:0] R0_IDX = IW'(2 * NUM_ELEMS + (IDX_R0 - IDX_R0));
  localparam logic [IW-1:0] R1_IDX = IW'(2 * NUM_ELEMS + (IDX_R1 - IDX_R0));
  localparam logic [IW-1:0] R2_IDX = IW'(2 * NUM_ELEMS + (IDX_R2 - IDX_R0));
  localparam logic [IW-1:0] R3_IDX = IW'(2 * NUM_ELEMS + (IDX_R3 - IDX_R0));
  localparam logic [EW-1:0] LAST_ELEM = EW'(NUM_ELEMS - 1);

  logic [31:0] a_mem [NUM_ELEMS];
  logic [31:0] b_mem [NUM_ELEMS];
  state_t      state, state_nxt;
  logic [EW-1:0] elem_i;
  logic [7:0]  cnt;
  logic        resp_q;
  logic [31:0] rdata_q;
  logic [31:0] r0, r1, r2;
  logic [31:0] rd_val;
  logic [IW-1:0] idx;
  logic [EW-1:0] op_sel;
  logic        is_a, is_b, is_res, stall, accept, op_wr, busy;
  logic        init, step, commit;
  logic        addr_unused;

  assign idx         = host_addr[ADDR_LSBS-1:2];
  assign addr_unused = ^{host_addr[31:ADDR_LSBS], host_addr[1:0]};
  // A and B blocks are NUM_ELEMS-aligned, so the low index bits select the element
  assign op_sel      = idx[EW-1:0];
  assign is_a        = (idx < B0_IDX);
  assign is_b        = (idx >= B0_IDX) && (idx < R0_IDX);
  assign is_res      = (idx >= R0_IDX) && (idx <= R2_IDX);
  assign busy        = (state != IDLE);

  // A write commits this cycle and starts a compute at the same edge, so
  // busy state covers the dirty window for any later result read.
  assign stall    = !host_we && is_res && busy;
  assign accept   = rst_ni && host_req && !resp_q && !stall;
  assign op_wr    = accept && host_we && (is_a || is_b);
  assign host_ack = accept;
  assign host_resp  = resp_q;
  assign host_rdata = rdata_q;

  always_comb begin
    rd_val = '0;
    if (is_a) begin
      rd_val = a_mem[op_sel];
    end else if (is_b) begin
      rd_val = b_mem[op_sel];
    end else if (idx == R0_IDX) begin
      rd_val = r0;
    end else if (idx == R1_IDX) begin
      rd_val = r1;
    end else if (idx == R2_IDX) begin
      rd_val = r2;
    end else if (idx == R3_IDX) begin
      rd_val = {16'h0, cnt, 7'h0, busy};
    end
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (op_wr) begin
          init      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (op_wr) begin
          init = 1'b1;
        end else if (elem_i == LAST_ELEM) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        commit    = 1'b1;
        init      = op_wr;
        state_nxt = op_wr ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      elem_i  <= '0;
      cnt     <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      for (int k = 0; k < NUM_ELEMS; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      state  <= state_nxt;
      resp_q <= accept && !host_we;
      if (accept && !host_we) rdata_q <= rd_val;
      if (init) elem_i <= '0;
      else if (step) elem_i <= elem_i + 1'b1;
      if (commit) cnt <= cnt + 8'd1;
      if (op_wr && is_a) a_mem[op_sel] <= byte_merge(a_mem[op_sel], host_wdata, host_be);
      if (op_wr && is_b) b_mem[op_sel] <= byte_merge(b_mem[op_sel], host_wdata, host_be);
    end
  end

  vec_accel_dp u_dp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .init   (init),
    .step   (step),
    .commit (commit),
    .a_elem (a_mem[elem_i]),
    .b_elem (b_mem[elem_i]),
    .r0     (r0),
    .r1     (r1),
    .r2     (r2)
  );

endmodule

// File: tb/tb_vec_accel_slave.sv
// tb/tb_vec_accel_slave.sv - directed and randomized bench for vec_accel_slave with a vector reference model
module tb_vec_accel_slave;

  localparam int N = 8;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [31:0] host_addr = '0;
  logic [3:0]  host_be = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic        host_resp;
  logic [31:0] host_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ack_cyc = 0;

  logic [31:0] ma [N];
  logic [31:0] mb [N];
  logic [7:0]  exp_cnt = 8'd0;

  vec_accel_slave dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_be    (host_be),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_resp  (host_resp),
    .host_rdata (host_rdata)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    @(negedge clk_i);
    while (!host_ack && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!host_ack) begin
      checks++;
      errors++;
      $error("FAIL ack_timeout: observed no ack expected ack within 200 cycles");
    end
    last_ack_cyc = cyc;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    int n;
    @(posedge clk_i); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = addr; host_wdata = data; host_be = be;
    wait_ack(n);
    @(posedge clk_i); #1;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data, output int waited);
    @(posedge clk_i); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = addr; host_be = 4'h0;
    wait_ack(waited);
    @(posedge clk_i); #1;
    host_req = 1'b0;
    @(negedge clk_i);
    check("resp_pulse", {31'h0, host_resp}, 32'h1);
    data = host_rdata;
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic op_write(input int idx, input logic [31:0] data, input logic [3:0] be);
    bus_wr(BASE + 32'(4 * idx), data, be);
    if (idx < N) ma[idx] = lane_merge(ma[idx], data, be);
    else mb[idx - N] = lane_merge(mb[idx - N], data, be);
  endtask

  // Reference: dot product, max and min of element-wise sums, all mod 2^32
  function automatic logic [31:0] model_res(input int which);
    logic [31:0] dot, mx, mn, s;
    logic [63:0] p;
    dot = 0; mx = 0; mn = 32'hFFFF_FFFF;
    for (int k = 0; k < N; k++) begin
      p = {32'h0, ma[k]} * {32'h0, mb[k]};
      dot = dot + p[31:0];
      s = ma[k] + mb[k];
      if (s > mx) mx = s;
      if (s < mn) mn = s;
    end
    return (which == 0) ? dot : (which == 1) ? mx : mn;
  endfunction

  task automatic check_results(input string tag);
    logic [31:0] v;
    int w;
    bus_rd(BASE + 32'h40, v, w); check({tag, "_r0"}, v, model_res(0));
    bus_rd(BASE + 32'h44, v, w); check({tag, "_r1"}, v, model_res(1));
    bus_rd(BASE + 32'h48, v, w); check({tag, "_r2"}, v, model_res(2));
    bus_rd(BASE + 32'h4C, v, w); check({tag, "_r3"}, v, {16'h0, exp_cnt, 8'h0});
  endtask

  initial begin
    logic [31:0] v;
    int w, t0, ri;
    logic [31:0] av [N];
    logic [31:0] bv [N];
    av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd7, 32'd6, 32'd5};
    bv = '{32'd7, 32'd5, 32'd3, 32'd1, 32'd4, 32'd6, 32'd8, 32'd10};
    for (int k = 0; k < N; k++) begin ma[k] = 0; mb[k] = 0; end

    // 1: reset state and first reads
    #23;
    check("rst_ack", {31'h0, host_ack}, 32'h0);
    check("rst_resp", {31'h0, host_resp}, 32'h0);
    check("rst_rdata", host_rdata, 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    bus_rd(BASE + 32'h4C, v, w); check("t1_status", v, 32'h0);
    bus_rd(BASE + 32'h40, v, w); check("t1_r0", v, 32'h0);
    check("t1_r0_nostall", 32'(w), 32'h0);

    // 2: slow host, every write runs to completion
    for (int k = 0; k < N; k++) begin op_write(k, av[k], 4'hF); exp_cnt++; idle(14); end
    for (int k = 0; k < N; k++) begin op_write(N + k, bv[k], 4'hF); exp_cnt++; idle(14); end
    bus_rd(BASE + 32'h40, v, w); check("t2_r0", v, 32'hCA);
    bus_rd(BASE + 32'h44, v, w); check("t2_r1", v, 32'hF);
    bus_rd(BASE + 32'h48, v, w); check("t2_r2", v, 32'h5);
    bus_rd(BASE + 32'h4C, v, w); check("t2_r3", v, 32'h0000_1000);

    // 3: result read right after a write stalls until the compute lands
    op_write(2 * N - 1, 32'hA, 4'hF); exp_cnt++;
    t0 = last_ack_cyc;
    bus_rd(BASE + 32'h40, v, w);
    check("t3_ack_delay", 32'(last_ack_cyc - t0), 32'(N + 2));
    check("t3_r0", v, 32'hCA);

    // 4: single byte-lane write
    op_write(0, 32'h0000_0100, 4'b0010); exp_cnt++;
    bus_rd(BASE + 32'h00, v, w); check("t4_a0", v, 32'h101);
    check("t4_a0_nostall", 32'(w), 32'h0);
    bus_rd(BASE + 32'h40, v, w); check("t4_r0", v, 32'h7CA);

    // 5: operand writes landing inside CALC restart the compute
    op_write(0, 32'h5, 4'hF);
    bus_rd(BASE + 32'h4C, v, w); check("t5_busy", {31'h0, v[0]}, 32'h1);
    check("t5_status_nostall", 32'(w), 32'h0);
    op_write(3, 32'h11, 4'hF); exp_cnt++;
    check_results("t5");
    op_write(2, 32'h21, 4'hF);
    idle(5);
    op_write(0, 32'h33, 4'hF); exp_cnt++;
    check_results("t5b");

    // randomized bursts checked against the model
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 2 * N; k++) begin
        case (it)
          0: v = $urandom();
          1: v = $urandom_range(0, 15);
          2: v = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom();
          default: v = $urandom();
        endcase
        op_write(k, v, (it == 3) ? 4'($urandom_range(1, 15)) : 4'hF);
      end
      exp_cnt++;
      check_results($sformatf("rnd%0d", it));
      ri = $urandom_range(0, 2 * N - 1);
      bus_rd(BASE + 32'(4 * ri), v, w);
      check($sformatf("rnd%0d_readback", it), v, (ri < N) ? ma[ri] : mb[ri - N]);
    end

    // unmapped and result-register writes are ignored
    bus_wr(BASE + 32'h50, 32'hDEAD_BEEF, 4'hF);
    bus_rd(BASE + 32'h50, v, w); check("unmapped_rd", v, 32'h0);
    bus_wr(BASE + 32'h40, 32'h1234_5678, 4'hF);
    check_results("ro_results");

    // 6: reset in the middle of CALC with a stalled read outstanding
    op_write(1, 32'h3, 4'hF);
    @(posedge clk_i); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = BASE + 32'h40;
    @(posedge clk_i); #1 rst_ni = 1'b0;
    @(negedge clk_i);
    check("t6_rst_ack", {31'h0, host_ack}, 32'h0);
    check("t6_rst_resp", {31'h0, host_resp}, 32'h0);
    check("t6_rst_rdata", host_rdata, 32'h0);
    host_req = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    for (int k = 0; k < N; k++) begin ma[k] = 0; mb[k] = 0; end
    exp_cnt = 0;
    bus_rd(BASE + 32'h40, v, w); check("t6_r0_cleared", v, 32'h0);
    bus_rd(BASE + 32'h4C, v, w); check("t6_status_cleared", v, 32'h0);
    op_write(0, 32'hFFFF_FFFF, 4'hF);
    op_write(N, 32'hFFFF_FFFF, 4'hF); exp_cnt++;
    bus_rd(BASE + 32'h40, v, w); check("t6_r0", v, 32'h1);
    bus_rd(BASE + 32'h44, v, w); check("t6_r1", v, 32'hFFFF_FFFE);
    bus_rd(BASE + 32'h48, v, w); check("t6_r2", v, 32'h0);
    bus_rd(BASE + 32'h4C, v, w); check("t6_r3", v, 32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
